// File: rtl/ysyx_22040237_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   FETCH_PC_W / FETCH_INST_W : default PC and instruction widths
//   FETCH_RESET_PC            : default fetch address after reset
//   fetch_entry_t             : one queued instruction {pc, inst[, fault]}
//   next_pc()                 : sequential fetch address
// Optional macro FETCH_ACCESS_FAULT_EN adds a fault bit to fetch_entry_t.
package ysyx_22040237_fetch_pkg;

    localparam int FETCH_PC_W   = 32;
    localparam int FETCH_INST_W = 32;
    localparam logic [FETCH_PC_W-1:0] FETCH_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_INST_W-1:0] inst;
`ifdef FETCH_ACCESS_FAULT_EN
        logic                    fault;
`endif
    } fetch_entry_t;

    function automatic logic [FETCH_PC_W-1:0] next_pc(input logic [FETCH_PC_W-1:0] pc);
        return pc + FETCH_PC_W'(4);
    endfunction

endpackage

// File: rtl/ysyx_22040237_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req_*  : request channel, fetch unit -> memory (valid/ready)
//   imem_rsp_*  : response channel, memory -> fetch unit (always accepted)
//   inst_*      : instruction queue head, fetch unit -> decode (valid/ready)
// Modports: master = fetch unit side, slave = memory/decode side.
// Optional macro FETCH_ACCESS_FAULT_EN adds imem_rsp_err and inst_fault.
interface ysyx_22040237_fetch_unit_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
`ifdef FETCH_ACCESS_FAULT_EN
    logic              imem_rsp_err;
    logic              inst_fault;
`endif

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_ACCESS_FAULT_EN
        output inst_fault,
        input  imem_rsp_err,
`endif
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_ACCESS_FAULT_EN
        input  inst_fault,
        output imem_rsp_err,
`endif
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

endinterface

// File: rtl/ysyx_22040237_fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush.
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the queue; overrides push and pop
//   count/empty    : occupancy
//   head           : current head entry, read straight from storage
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_22040237_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_22040237_fetch_unit.sv
// Instruction-fetch unit: issues sequential PC requests to instruction
// memory (up to MAX_INFLIGHT outstanding), queues returned instructions with
// their PCs, and presents the queue head to decode. A redirect flushes the
// queue, restarts fetch at the new PC and discards in-flight responses.
// Ports:
//   clk, rst                    : clock, async active-low reset
//   redirect_valid, redirect_pc : restart fetch (pc bits [1:0] ignored)
//   bus (master)                : imem request/response and inst queue head
// Optional macro FETCH_ACCESS_FAULT_EN: errored responses become fault
// entries (inst=0) and fetch halts until the next redirect.
module ysyx_22040237_fetch_unit
    import ysyx_22040237_fetch_pkg::*;
#(
    parameter int              PC_W         = FETCH_PC_W,
    parameter int              INST_W       = FETCH_INST_W,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(FETCH_RESET_PC),
    parameter int              FIFO_DEPTH   = 4,
    parameter int              MAX_INFLIGHT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    ysyx_22040237_fetch_unit_if.master bus
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(FIFO_DEPTH + MAX_INFLIGHT + 1);
`ifdef FETCH_ACCESS_FAULT_EN
    localparam int FW = 1;
`else
    localparam int FW = 0;
`endif
    localparam int EW = PC_W + INST_W + FW;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [PC_W-1:0] redirect_aligned;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   drop_cnt;
    logic [IW-1:0]   live;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   credit_sum;
    logic            fifo_empty;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            halted;

    assign redirect_aligned = redirect_pc & ~PC_W'(3);

    // Only requests not already doomed by a redirect reserve queue space.
    assign live       = inflight - drop_cnt;
    assign credit_sum = SW'(fifo_count) + SW'(live);

    // Gated by rst so the request line is low while reset is held.
    assign bus.imem_req_valid = rst && !redirect_valid && !halted
                             && (inflight < IW'(MAX_INFLIGHT))
                             && (credit_sum < SW'(FIFO_DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error; ignore it.
    assign rsp_fire = bus.imem_rsp_valid && (inflight != '0);
    assign rsp_drop = redirect_valid || (drop_cnt != '0) || halted;
    assign push     = rsp_fire && !rsp_drop;
    assign pop      = bus.inst_valid && bus.inst_ready;

`ifdef FETCH_ACCESS_FAULT_EN
    logic [INST_W-1:0] push_inst;
    assign push_inst      = bus.imem_rsp_err ? {INST_W{1'b0}} : bus.imem_rsp_data;
    assign push_data      = {rsp_pc, push_inst, bus.imem_rsp_err};
    assign bus.inst_fault = head[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         halted <= 1'b0;
        else if (redirect_valid)          halted <= 1'b0;
        else if (push && bus.imem_rsp_err) halted <= 1'b1;
    end
`else
    assign push_data = {rsp_pc, bus.imem_rsp_data};
    assign halted    = 1'b0;
`endif

    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_pc    = head[EW-1 -: PC_W];
    assign bus.inst       = head[EW-PC_W-1 -: INST_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the
            // old stream and must be discarded on arrival.
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            inflight <= inflight - IW'(rsp_fire);
            drop_cnt <= inflight - IW'(rsp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_W'(4);
            if (push)     rsp_pc   <= rsp_pc + PC_W'(4);
            inflight <= inflight + IW'(req_fire) - IW'(rsp_fire);
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    ysyx_22040237_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (head),
        .empty     (fifo_empty)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rsp_valid |-> (inflight != '0));
    a_push_has_room: assert property (@(posedge clk) disable iff (!rst)
        push |-> (fifo_count != CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ysyx_22040237_fetch_unit.sv
module tb_ysyx_22040237_fetch_unit;
    import ysyx_22040237_fetch_pkg::*;

    localparam int PC_W         = 32;
    localparam int INST_W       = 32;
    localparam int FIFO_DEPTH   = 4;
    localparam int MAX_INFLIGHT = 2;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    ysyx_22040237_fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

    ysyx_22040237_fetch_unit #(
        .PC_W         (PC_W),
        .INST_W       (INST_W),
        .RESET_PC     (RESET_PC),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // stimulus knobs
    logic        ctl_redirect = 0, ctl_req_ready = 0, ctl_inst_ready = 0;
    logic [31:0] ctl_redirect_pc = '0;
    int          mem_mode = 0;   // 0: latency 1, 1: random latency, 2: hold responses

    // reference model state
    logic [31:0] mq_addr[$];
    int          mq_cyc[$];
    logic [31:0] exp_req_addr, exp_pc, prev_acc, last_pop_pc, first_pop_pc;
    int          cyc = 0, accepted = 0, popped = 0;
    int          first_acc_cyc = -1, first_val_cyc = -1;
    logic        last_rsp = 0, last_pop = 0, saw_wrap = 0;
`ifdef FETCH_ACCESS_FAULT_EN
    int          rsp_n = 0, err_at = -1;
    logic [31:0] fault_pc = '0;
    logic        fault_armed = 0, faulted = 0;
`endif

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_1E07;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_valid"}, bus.imem_req_valid, 0);
        chk({pfx, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        chk({pfx, "_inst_valid"}, bus.inst_valid, 0);
        chk({pfx, "_inst"}, bus.inst, 0);
        chk({pfx, "_inst_pc"}, bus.inst_pc, 0);
    endtask

    task automatic cycle();
        logic [31:0] a;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
`ifdef FETCH_ACCESS_FAULT_EN
        bus.imem_rsp_err   = 1'b0;
`endif
        last_rsp = 1'b0;
        if (mem_mode != 2 && mq_addr.size() != 0) begin
            if (mq_cyc[0] < cyc && (mem_mode == 0 || $urandom_range(0, 2) != 0)) begin
                a = mq_addr.pop_front();
                void'(mq_cyc.pop_front());
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = inst_of(a);
                last_rsp = 1'b1;
`ifdef FETCH_ACCESS_FAULT_EN
                rsp_n++;
                if (rsp_n == err_at) begin
                    bus.imem_rsp_err = 1'b1;
                    fault_pc = a;
                    fault_armed = 1'b1;
                end
`endif
            end
        end
        redirect_valid     = ctl_redirect;
        redirect_pc        = ctl_redirect_pc;
        bus.imem_req_ready = ctl_req_ready;
        bus.inst_ready     = ctl_inst_ready;
        #1;
        last_pop = bus.inst_valid && bus.inst_ready;
        if (bus.inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (redirect_valid) begin
            chk("req_held_on_redirect", bus.imem_req_valid, 0);
            exp_req_addr = {redirect_pc[31:2], 2'b00};
            exp_pc       = exp_req_addr;
`ifdef FETCH_ACCESS_FAULT_EN
            fault_armed = 1'b0;
            faulted     = 1'b0;
`endif
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, exp_req_addr);
                if (bus.imem_req_addr == 32'h0 && prev_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                prev_acc = bus.imem_req_addr;
                mq_addr.push_back(bus.imem_req_addr);
                mq_cyc.push_back(cyc);
                exp_req_addr = next_pc(exp_req_addr);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                accepted++;
                chk("inflight_bound", mq_addr.size() <= MAX_INFLIGHT, 1);
            end
            if (last_pop) begin
                chk("inst_pc", bus.inst_pc, exp_pc);
`ifdef FETCH_ACCESS_FAULT_EN
                if (faulted) chk("pop_after_fault", bus.inst_valid, 0);
                else if (fault_armed && exp_pc == fault_pc) begin
                    chk("fault_flag", bus.inst_fault, 1);
                    chk("fault_inst", bus.inst, 0);
                    faulted = 1'b1;
                end else begin
                    chk("inst", bus.inst, inst_of(exp_pc));
                    chk("no_fault", bus.inst_fault, 0);
                end
`else
                chk("inst", bus.inst, inst_of(exp_pc));
`endif
                if (popped == 0) first_pop_pc = bus.inst_pc;
                last_pop_pc = bus.inst_pc;
                exp_pc = next_pc(exp_pc);
                popped++;
            end
        end
        cyc++;
    endtask

    initial begin
        int k, base;
        logic found;
        logic [31:0] p0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
`ifdef FETCH_ACCESS_FAULT_EN
        bus.imem_rsp_err   = 1'b0;
`endif
        exp_req_addr = RESET_PC;
        exp_pc       = RESET_PC;
        prev_acc     = '0;
        last_pop_pc  = '0;
        first_pop_pc = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;

        // streaming, 1-cycle memory: first instruction two cycles after accept
        ctl_req_ready = 1; ctl_inst_ready = 1; mem_mode = 0;
        repeat (12) cycle();
        chk("first_inst_latency", first_val_cyc - first_acc_cyc, 2);
        chk("first_inst_pc", first_pop_pc, RESET_PC);

        // decode stalled: queue fills to depth and requests stop
        ctl_inst_ready = 0;
        repeat (20) cycle();
        chk("fill_req_stopped", bus.imem_req_valid, 0);
        chk("fill_inflight_zero", mq_addr.size(), 0);
        chk("fill_queued", accepted - popped, FIFO_DEPTH);
        ctl_inst_ready = 1;
        base = popped;
        repeat (12) cycle();
        chk("drain_progress", (popped - base) >= 8, 1);

        // redirect with two requests in flight
        mem_mode = 2;
        k = 0;
        while (mq_addr.size() < 2 && k < 20) begin cycle(); k++; end
        chk("two_inflight", mq_addr.size(), 2);
        ctl_redirect = 1; ctl_redirect_pc = 32'h8000_1002;
        cycle();
        ctl_redirect = 0; mem_mode = 0;
        base = popped; p0 = '0; k = 0;
        while ((popped - base) < 2 && k < 30) begin
            cycle();
            if (popped - base == 1 && p0 == '0) p0 = last_pop_pc;
            k++;
        end
        chk("redir_first_pc", p0, 32'h8000_1000);
        chk("redir_second_pc", last_pop_pc, 32'h8000_1004);

        // redirect coinciding with a response and a decode pop
        found = 0; k = 0;
        while (!found && k < 10) begin
            repeat (4) cycle();
            ctl_redirect = 1; ctl_redirect_pc = 32'h8000_2000 + 32'(k * 64);
            cycle();
            ctl_redirect = 0;
            found = last_rsp && last_pop;
            k++;
        end
        chk("redir_rsp_pop_seen", found, 1);
        cycle();
        chk("flush_empty_next", bus.inst_valid, 0);
        repeat (10) cycle();

        // address wrap
        ctl_redirect = 1; ctl_redirect_pc = 32'hFFFF_FFFA;
        cycle();
        ctl_redirect = 0;
        repeat (10) cycle();
        chk("pc_wrap_seen", saw_wrap, 1);

        // randomized traffic
        mem_mode = 1;
        base = popped;
        repeat (3000) begin
            ctl_req_ready   = ($urandom_range(0, 3) != 0);
            ctl_inst_ready  = ($urandom_range(0, 3) != 0);
            ctl_redirect    = ($urandom_range(0, 29) == 0);
            ctl_redirect_pc = $urandom();
            cycle();
        end
        ctl_redirect = 0;
        chk("random_progress", (popped - base) > 500, 1);

        // reset in the middle of traffic
        rst = 1'b0;
        redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        mq_addr.delete();
        mq_cyc.delete();
        #1;
        check_reset_outputs("midrst");
        exp_req_addr = RESET_PC;
        exp_pc = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
        ctl_req_ready = 1; ctl_inst_ready = 1;
        base = popped;
        repeat (40) cycle();
        chk("post_reset_progress", (popped - base) >= 5, 1);

`ifdef FETCH_ACCESS_FAULT_EN
        // errored third response: fault entry, halt, resume on redirect
        ctl_req_ready = 0; mem_mode = 0;
        repeat (6) cycle();
        rsp_n = 0; err_at = 3;
        ctl_redirect = 1; ctl_redirect_pc = 32'h8000_3000;
        cycle();
        ctl_redirect = 0; ctl_req_ready = 1;
        k = 0;
        while (!faulted && k < 30) begin cycle(); k++; end
        chk("fault_seen", faulted, 1);
        base = accepted;
        repeat (10) cycle();
        chk("halt_no_req", accepted - base, 0);
        chk("halt_req_valid", bus.imem_req_valid, 0);
        err_at = -1;
        ctl_redirect = 1; ctl_redirect_pc = 32'h8000_4000;
        cycle();
        ctl_redirect = 0;
        base = popped;
        repeat (10) cycle();
        chk("resume_after_fault", (popped - base) >= 4, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
